// File: rtl/sseg_core_pkg.sv
// rtl/sseg_core_pkg.sv - register map and shared constants for the seven-segment scan core
package sseg_core_pkg;

  localparam logic [4:0] DATA_BASE  = 5'd0;
  localparam logic [4:0] CTRL_ADDR  = 5'd16;
  localparam logic [4:0] STAT_ADDR  = 5'd17;

  localparam int         EN_BIT     = 0;
  localparam int         BRIGHT_LSB = 8;
  localparam int         BLINK_LSB  = 16;

  localparam logic [7:0] SSEG_BLANK = 8'hFF;

endpackage

// File: rtl/sseg_scan_timer.sv
// rtl/sseg_scan_timer.sv - dwell, digit index and frame counters for the display scan
module sseg_scan_timer #(
  parameter int N_DIGITS = 8,
  parameter int DWELL_W  = 16,
  parameter int BLINK_W  = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  output logic [$clog2(N_DIGITS)-1:0] idx,
  output logic [DWELL_W-1:0]          dcnt,
  output logic                        blink_phase
);

  localparam int IDX_W = $clog2(N_DIGITS);

  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLINK_W-1:0] fcnt_q, fcnt_d;

  // Holding everything at zero while disabled makes re-enable restart at digit 0.
  always_comb begin
    dcnt_d = dcnt_q + DWELL_W'(1);
    idx_d  = idx_q;
    fcnt_d = fcnt_q;
    if (dcnt_q == '1) begin
      if (idx_q == IDX_W'(N_DIGITS - 1)) begin
        idx_d  = '0;
        fcnt_d = fcnt_q + BLINK_W'(1);
      end else begin
        idx_d  = idx_q + IDX_W'(1);
      end
    end
    if (!enable) begin
      dcnt_d = '0;
      idx_d  = '0;
      fcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt_q <= '0;
      idx_q  <= '0;
      fcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_d;
      idx_q  <= idx_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign idx         = idx_q;
  assign dcnt        = dcnt_q;
  assign blink_phase = fcnt_q[BLINK_W-1];

endmodule

// File: rtl/sseg_scan_pwm_core.sv
// rtl/sseg_scan_pwm_core.sv - MMIO seven-segment scanner with PWM brightness, guard blanking and blink
module sseg_scan_pwm_core
  import sseg_core_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DWELL_W  = 16,
  parameter int BRIGHT_W = 4,
  parameter int GUARD    = 16,
  parameter int BLINK_W  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic                read,
  input  logic                write,
  input  logic [4:0]          addr,
  input  logic [31:0]         wr_data,
  output logic [31:0]         rd_data,
  output logic [7:0]          sseg,
  output logic [N_DIGITS-1:0] an
);

  localparam int N_WORDS = N_DIGITS / 4;
  localparam int IDX_W   = $clog2(N_DIGITS);

  logic [8*N_DIGITS-1:0] pat_q, pat_d;
  logic                  en_q, en_d;
  logic [BRIGHT_W-1:0]   bright_q, bright_d;
  logic [N_DIGITS-1:0]   blink_q, blink_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [7:0]            sseg_q, sseg_d;

  logic [IDX_W-1:0]      idx;
  logic [DWELL_W-1:0]    dcnt;
  logic                  blink_phase;
  logic                  bright_on;
  logic                  lit;
  logic                  rd_unused;

  // rd_data is a pure address mux, so the read strobe has no side effects.
  assign rd_unused = read;

  sseg_scan_timer #(
    .N_DIGITS (N_DIGITS),
    .DWELL_W  (DWELL_W),
    .BLINK_W  (BLINK_W)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .enable      (en_q),
    .idx         (idx),
    .dcnt        (dcnt),
    .blink_phase (blink_phase)
  );

  always_comb begin
    pat_d    = pat_q;
    en_d     = en_q;
    bright_d = bright_q;
    blink_d  = blink_q;
    if (cs && write) begin
      for (int k = 0; k < N_WORDS; k++) begin
        if (addr == DATA_BASE + 5'(k)) pat_d[32*k +: 32] = wr_data;
      end
      if (addr == CTRL_ADDR) begin
        en_d     = wr_data[EN_BIT];
        bright_d = wr_data[BRIGHT_LSB +: BRIGHT_W];
        blink_d  = wr_data[BLINK_LSB +: N_DIGITS];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      if (addr == DATA_BASE + 5'(k)) rd_data = pat_q[32*k +: 32];
    end
    if (addr == CTRL_ADDR) begin
      rd_data[EN_BIT]                   = en_q;
      rd_data[BRIGHT_LSB +: BRIGHT_W]   = bright_q;
      rd_data[BLINK_LSB +: N_DIGITS]    = blink_q;
    end
    if (addr == STAT_ADDR) begin
      rd_data[3:0] = 4'(idx);
      rd_data[8]   = blink_phase;
    end
  end

  // PWM compares the top dwell bits with bright; full scale bypasses it so the digit stays on.
  always_comb begin
    bright_on = (bright_q == '1) || (dcnt[DWELL_W-1 -: BRIGHT_W] < bright_q);
    lit       = en_q && (dcnt >= DWELL_W'(GUARD)) && bright_on
                && !(blink_q[idx] && blink_phase);
    an_d      = '1;
    sseg_d    = SSEG_BLANK;
    if (lit) begin
      an_d   = ~(N_DIGITS'(1) << idx);
      sseg_d = pat_q[{idx, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q    <= '0;
      en_q     <= 1'b1;
      bright_q <= '1;
      blink_q  <= '0;
      an_q     <= '1;
      sseg_q   <= SSEG_BLANK;
    end else begin
      pat_q    <= pat_d;
      en_q     <= en_d;
      bright_q <= bright_d;
      blink_q  <= blink_d;
      an_q     <= an_d;
      sseg_q   <= sseg_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_sseg_scan_pwm_core.sv
// tb/tb_sseg_scan_pwm_core.sv - directed bench for sseg_scan_pwm_core (8 digits, 16-cycle dwell)
module tb_sseg_scan_pwm_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [7:0]  sseg;
  logic [7:0]  an;

  sseg_scan_pwm_core #(
    .N_DIGITS (8),
    .DWELL_W  (4),
    .BRIGHT_W (2),
    .GUARD    (1),
    .BLINK_W  (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .sseg    (sseg),
    .an      (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [7:0] sseg;
  } vec_t;

  vec_t        vecs [13];
  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  int          lit_cnt [8];
  int          bad_sseg;
  logic [31:0] rv;
  logic        ok;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; read = 1'b0; addr = a; wr_data = d;
    tick();
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic wait_an(input logic [7:0] target, input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (an === target) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic count_window(input int n);
    for (int d = 0; d < 8; d++) lit_cnt[d] = 0;
    bad_sseg = 0;
    for (int i = 0; i < n; i++) begin
      for (int d = 0; d < 8; d++) if (!an[d]) lit_cnt[d]++;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0,   8'hFF, 8'hFF};
    vecs[1]  = '{1,   8'hFF, 8'hFF};
    vecs[2]  = '{2,   8'hFE, 8'h00};
    vecs[3]  = '{15,  8'hFE, 8'h00};
    vecs[4]  = '{16,  8'hFE, 8'h00};
    vecs[5]  = '{17,  8'hFF, 8'hFF};
    vecs[6]  = '{18,  8'hFD, 8'h00};
    vecs[7]  = '{33,  8'hFF, 8'hFF};
    vecs[8]  = '{34,  8'hFB, 8'h00};
    vecs[9]  = '{114, 8'h7F, 8'h00};
    vecs[10] = '{128, 8'h7F, 8'h00};
    vecs[11] = '{129, 8'hFF, 8'hFF};
    vecs[12] = '{130, 8'hFE, 8'h00};

    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;

    rd(5'd16, rv); check("reset_ctrl", rv, 32'h0000_0301);
    rd(5'd17, rv); check("reset_status", rv, 32'h0);
    rd(5'd0, rv);  check("reset_data0", rv, 32'h0);

    // Free-running scan from reset, spot-checked against hand-computed cycles.
    for (int v = 0; v < 13; v++) begin
      while (cyc < vecs[v].cyc) tick();
      check($sformatf("scan_an_c%0d", vecs[v].cyc), an, vecs[v].an);
      check($sformatf("scan_sseg_c%0d", vecs[v].cyc), sseg, vecs[v].sseg);
    end

    for (int d = 0; d < 8; d++) lit_cnt[d] = 0;
    bad_sseg = 0;
    for (int i = 0; i < 128; i++) begin
      for (int d = 0; d < 8; d++) if (!an[d]) lit_cnt[d]++;
      if (an !== 8'hFF && sseg !== 8'h00) bad_sseg++;
      tick();
    end
    for (int d = 0; d < 8; d++) check($sformatf("full_dwell_d%0d", d), lit_cnt[d], 15);
    check("full_sseg_zero", bad_sseg, 0);

    wr(5'd0, 32'h1122_3344);
    wr(5'd1, 32'h5566_7788);
    rd(5'd0, rv); check("readback0", rv, 32'h1122_3344);
    rd(5'd1, rv); check("readback1", rv, 32'h5566_7788);
    wait_an(8'hEF, 300, ok); check("wait_d4", ok, 1);
    check("sseg_d4", sseg, 8'h88);
    wait_an(8'hFE, 300, ok); check("wait_d0", ok, 1);
    check("sseg_d0", sseg, 8'h44);

    // Rewrite the digit currently on display: old pattern for one more cycle, then new.
    wait_an(8'hFF, 300, ok); check("wait_blank", ok, 1);
    wait_an(8'hFE, 300, ok); check("wait_d0_first", ok, 1);
    wr(5'd0, 32'h1122_33AA);
    check("live_an0", an, 8'hFE);
    check("live_sseg0", sseg, 8'h44);
    tick();
    check("live_an1", an, 8'hFE);
    check("live_sseg1", sseg, 8'hAA);

    cs = 1'b1; read = 1'b1; write = 1'b1; addr = 5'd1; wr_data = 32'hCAFE_F00D;
    #1;
    check("rw_same_old", rd_data, 32'h5566_7788);
    tick();
    write = 1'b0;
    #1;
    check("rw_same_new", rd_data, 32'hCAFE_F00D);

    wr(5'd20, 32'hFFFF_FFFF);
    wr(5'd2, 32'hFFFF_FFFF);
    rd(5'd20, rv); check("unmapped20", rv, 32'h0);
    rd(5'd2, rv);  check("unmapped2", rv, 32'h0);
    rd(5'd0, rv);  check("data0_intact", rv, 32'h1122_33AA);

    wr(5'd16, 32'h0000_0101);
    tick();
    count_window(128);
    for (int d = 0; d < 8; d++) check($sformatf("bright1_d%0d", d), lit_cnt[d], 3);
    wait_an(8'hFF, 300, ok);
    wait_an(8'hFB, 300, ok); check("wait_b1_d2", ok, 1);
    tick(); check("b1_dcnt2", an, 8'hFB);
    tick(); check("b1_dcnt3", an, 8'hFB);
    tick(); check("b1_dcnt4", an, 8'hFF);

    wr(5'd16, 32'h0000_0001);
    tick();
    count_window(128);
    check("bright0_sum", lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3]
                         + lit_cnt[4] + lit_cnt[5] + lit_cnt[6] + lit_cnt[7], 0);

    wr(5'd16, 32'h0001_0301);
    rd(5'd16, rv); check("ctrl_blink_rb", rv, 32'h0001_0301);
    tick();
    count_window(256);
    check("blink_d0", lit_cnt[0], 15);
    check("blink_d1", lit_cnt[1], 30);

    wr(5'd16, 32'h0000_0300);
    tick();
    for (int i = 0; i < 10; i++) begin
      rd(5'd17, rv);
      check($sformatf("dis_idx_%0d", i), rv[3:0], 4'h0);
      check($sformatf("dis_an_%0d", i), an, 8'hFF);
      tick();
    end
    wr(5'd16, 32'h0000_0301);
    check("reen_an0", an, 8'hFF);
    tick(); check("reen_an1", an, 8'hFF);
    rd(5'd17, rv); check("reen_idx", rv, 32'h0);
    tick(); check("reen_an2", an, 8'hFE);
    tick(); check("reen_an3", an, 8'hFE);

    wr(5'd16, 32'h0000_0101);
    wait_an(8'hDF, 300, ok); check("wait_d5", ok, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_an", an, 8'hFF);
    check("rst_sseg", sseg, 8'hFF);
    rd(5'd16, rv); check("rst_ctrl", rv, 32'h0000_0301);
    rd(5'd0, rv);  check("rst_data0", rv, 32'h0);
    rd(5'd1, rv);  check("rst_data1", rv, 32'h0);
    rd(5'd17, rv); check("rst_status", rv, 32'h0);
    rd(5'd20, rv); check("rst_addr20", rv, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
